// File: rtl/data_sync_tx.sv
// Source-domain transmitter for a multi-flop bus synchronizer: holds a word on
// unsync_bus under a level enable and completes on a synchronized 4-phase ack.
module data_sync_tx #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    input  logic                 dest_ack,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 busy
);
    localparam int            TW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_REQ     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_STAGES-1:0]  r_ack_sync;
    logic [TW-1:0]          r_timer;
    logic                   r_ack_exit;
    logic [BUS_WIDTH-1:0]   r_bus;
    logic                   r_en;
    logic                   r_done;
    logic                   r_to;

    logic                   w_ack_s;
    logic                   w_accept;
    logic                   w_timer_hit;
    logic                   w_load;
    logic                   w_en_nxt;
    logic                   w_done_nxt;
    logic                   w_to_nxt;
    logic                   w_ack_exit_nxt;

    assign w_ack_s     = r_ack_sync[NUM_STAGES-1];
    assign tx_ready    = (r_state == S_IDLE) && !RST;
    assign busy        = (r_state != S_IDLE);
    assign w_accept    = tx_valid && tx_ready;
    assign w_timer_hit = TO_EN && (r_timer == TMR_LAST);

    assign unsync_bus  = r_bus;
    assign bus_enable  = r_en;
    assign done        = r_done;
    assign timeout_err = r_to;

    // dest_ack synchronizer chain; only its last stage feeds control decisions
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync[0] <= dest_ack;
            for (int i = 1; i < NUM_STAGES; i++) begin
                r_ack_sync[i] <= r_ack_sync[i-1];
            end
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_en_nxt       = r_en;
        w_done_nxt     = 1'b0;
        w_to_nxt       = 1'b0;
        w_ack_exit_nxt = r_ack_exit;
        case (r_state)
            S_IDLE: begin
                w_en_nxt = 1'b0;
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                w_en_nxt       = 1'b1;
                w_ack_exit_nxt = 1'b0;
                w_state_nxt    = S_REQ;
            end
            S_REQ: begin
                // An ack already high on entry counts as a real ack
                if (w_ack_s) begin
                    w_en_nxt       = 1'b0;
                    w_ack_exit_nxt = 1'b1;
                    w_state_nxt    = S_RELEASE;
                end else if (w_timer_hit) begin
                    w_en_nxt       = 1'b0;
                    w_to_nxt       = 1'b1;
                    w_ack_exit_nxt = 1'b0;
                    w_state_nxt    = S_RELEASE;
                end else begin
                    w_en_nxt       = 1'b1;
                end
            end
            S_RELEASE: begin
                w_en_nxt = 1'b0;
                if (!w_ack_s) begin
                    w_done_nxt  = r_ack_exit;
                    w_state_nxt = S_IDLE;
                end else if (w_timer_hit) begin
                    w_to_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RELEASE;
                end
            end
            default: begin
                w_en_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Wait timer: restarts on every state change, counts only while waiting
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_RELEASE)) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= '0;
        end
    end

    // Registered outputs; the bus word changes only on accept
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bus      <= '0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_to       <= 1'b0;
            r_ack_exit <= 1'b0;
        end else begin
            r_bus      <= w_load ? tx_data : r_bus;
            r_en       <= w_en_nxt;
            r_done     <= w_done_nxt;
            r_to       <= w_to_nxt;
            r_ack_exit <= w_ack_exit_nxt;
        end
    end

    data_sync_tx_chk #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_chk (
        .CLK        (CLK),
        .RST        (RST),
        .unsync_bus (r_bus),
        .bus_enable (r_en),
        .done       (r_done),
        .timeout_err(r_to),
        .busy       (busy)
    );

endmodule

// Protocol invariants of the transmitter outputs.
module data_sync_tx_chk #(
    parameter int BUS_WIDTH = 8
) (
    input logic                 CLK,
    input logic                 RST,
    input logic [BUS_WIDTH-1:0] unsync_bus,
    input logic                 bus_enable,
    input logic                 done,
    input logic                 timeout_err,
    input logic                 busy
);
    a_done_to_excl: assert property (@(posedge CLK) disable iff (RST) !(done && timeout_err));
    a_en_busy:      assert property (@(posedge CLK) disable iff (RST) bus_enable |-> busy);
    a_setup_stable: assert property (@(posedge CLK) disable iff (RST) $rose(bus_enable) |-> $stable(unsync_bus));
endmodule
